// File: rtl/count_event.sv
// count_event: arms on a pulse, then raises a registered interrupt when the
// upstream counter hits a compare value (or wraps, when enabled). It also
// counts direction changes of the counter, saturating at all-ones.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   count_in   16-bit value from the upstream up/down counter
//   dir_in     direction of the step that produced count_in (1 = down)
//   cmp_val    16-bit compare value, sampled every cycle
//   arm        single-cycle pulse, IDLE -> ARMED
//   irq_ack    single-cycle pulse, acknowledges the interrupt in FIRED
//   irq        registered interrupt request, high throughout FIRED
//   evt_match  sticky compare-match flag
//   evt_wrap   sticky wrap flag (always 0 unless COUNT_EVENT_WRAP_EN)
//   dir_flips  saturating count of direction changes, cleared on arm
//   armed      high while in ARMED
//
// Build option: define COUNT_EVENT_WRAP_EN to add wrap detection
// (FFFF->0000 counting up, 0000->FFFF counting down) as a second fire source.
module count_event #(
    parameter int FLIP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       count_in,
    input  logic              dir_in,
    input  logic [15:0]       cmp_val,
    input  logic              arm,
    input  logic              irq_ack,
    output logic              irq,
    output logic              evt_match,
    output logic              evt_wrap,
    output logic [FLIP_W-1:0] dir_flips,
    output logic              armed
);

    typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

    state_t state, next_state;
    logic   prev_dir, prev_valid;
    logic   match, wrap, fire, flip, accept_arm, ack;

    // Events are only evaluated in ARMED, so the edge that accepts arm
    // never fires even if count_in already equals cmp_val.
    assign match      = state == ARMED && count_in == cmp_val;
    assign fire       = match || wrap;
    assign flip       = prev_valid && dir_in != prev_dir;
    assign accept_arm = state == IDLE && arm;
    assign ack        = state == FIRED && irq_ack;
    assign armed      = state == ARMED;

`ifdef COUNT_EVENT_WRAP_EN
    logic [15:0] prev_cnt;

    assign wrap = state == ARMED && prev_valid &&
                  ((prev_cnt == 16'hFFFF && count_in == 16'h0000 && !dir_in) ||
                   (prev_cnt == 16'h0000 && count_in == 16'hFFFF &&  dir_in));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cnt <= 16'h0000;
            evt_wrap <= 1'b0;
        end else begin
            prev_cnt <= count_in;
            if (wrap)
                evt_wrap <= 1'b1;
            else if (ack)
                evt_wrap <= 1'b0;
        end
    end
`else
    assign wrap     = 1'b0;
    assign evt_wrap = 1'b0;
`endif

    always_comb begin
        next_state = state;
        if (accept_arm)
            next_state = ARMED;
        else if (fire)
            next_state = FIRED;
        else if (ack)
            next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            irq        <= 1'b0;
            evt_match  <= 1'b0;
            dir_flips  <= '0;
            prev_dir   <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            state      <= next_state;
            prev_dir   <= dir_in;
            prev_valid <= 1'b1;
            if (fire)
                irq <= 1'b1;
            else if (ack)
                irq <= 1'b0;
            if (match)
                evt_match <= 1'b1;
            else if (ack)
                evt_match <= 1'b0;
            // Arming restarts the count; a flip on the arming edge counts as 1.
            if (accept_arm)
                dir_flips <= FLIP_W'(flip);
            else if (flip && dir_flips != '1)
                dir_flips <= dir_flips + FLIP_W'(1);
        end
    end

endmodule

// File: tb/tb_count_event.sv
// tb_count_event: directed scoreboard bench for count_event.
module tb_count_event;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] count_in = 16'h0;
    logic        dir_in = 1'b0;
    logic [15:0] cmp_val = 16'h0;
    logic        arm = 1'b0;
    logic        irq_ack = 1'b0;
    logic        irq, evt_match, evt_wrap, armed;
    logic [7:0]  dir_flips;

    count_event #(.FLIP_W(8)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .dir_in(dir_in),
        .cmp_val(cmp_val), .arm(arm), .irq_ack(irq_ack), .irq(irq),
        .evt_match(evt_match), .evt_wrap(evt_wrap), .dir_flips(dir_flips),
        .armed(armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  irq, m, w, a;
        int    flips;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".irq"},   32'(irq),       32'd0);
        chk({tag, ".match"}, 32'(evt_match), 32'd0);
        chk({tag, ".wrap"},  32'(evt_wrap),  32'd0);
        chk({tag, ".armed"}, 32'(armed),     32'd0);
        chk({tag, ".flips"}, 32'(dir_flips), 32'd0);
    endtask

    // Drive one cycle of stimulus, push its expected outcome, and compare
    // the popped expectation against the outputs just after the edge.
    task automatic step(input string tag, input logic [15:0] c, input logic d,
                        input logic a, input logic k, input logic ei, input logic em,
                        input logic ew, input logic ea, input int ef);
        exp_t e;
        sb.push_back('{tag, ei, em, ew, ea, ef});
        count_in = c;
        dir_in   = d;
        arm      = a;
        irq_ack  = k;
        @(posedge clk);
        #1;
        arm     = 1'b0;
        irq_ack = 1'b0;
        e = sb.pop_front();
        chk({e.tag, ".irq"},   32'(irq),       32'(e.irq));
        chk({e.tag, ".match"}, 32'(evt_match), 32'(e.m));
        chk({e.tag, ".wrap"},  32'(evt_wrap),  32'(e.w));
        chk({e.tag, ".armed"}, 32'(armed),     32'(e.a));
        if (e.flips >= 0)
            chk({e.tag, ".flips"}, 32'(dir_flips), 32'(e.flips));
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // arm, count up to the compare value, acknowledge
        cmp_val = 16'h0005;
        step("arm0", 16'd0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++)
            step("cnt", 16'(i), 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 0);
        step("hit5",     16'd5, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, -1);
        step("hold",     16'd6, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, -1);
        step("ack",      16'd7, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        step("ack_idle", 16'd5, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);

        // wrap up and down
        cmp_val = 16'h1234;
`ifdef COUNT_EVENT_WRAP_EN
        step("warm_up", 16'hFFFF, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0);
        step("wrap_up", 16'h0000, 1'b0, 1'b0, 1'b0, 1, 0, 1, 0, 0);
        step("wack_up", 16'h0000, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        step("warm_dn", 16'h0000, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 1);
        step("wrap_dn", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 1);
        step("wack_dn", 16'hFFFF, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1);
`else
        step("warm_up",   16'hFFFF, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0);
        step("nowrap_up", 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 0);
        step("dn0",       16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 1);
        step("nowrap_dn", 16'hFFFF, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 1);
        step("fire_1234", 16'h1234, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 1);
        step("ack_1234",  16'h1234, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1);
`endif

        // match present on the arming edge is not evaluated; arm ignored in FIRED
        cmp_val = 16'h0042;
        step("arm_eq",    16'h0042, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0);
        step("eq_hold",   16'h0042, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        step("arm_fired", 16'h0042, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 0);
        step("ack2",      16'h0042, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        step("arm3",      16'h0100, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0);
        step("ack_armed", 16'h0100, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1, 0);

        // 300 direction flips saturate at 255
        for (int i = 1; i <= 300; i++)
            step("tog", 16'h0100, (i % 2 == 0), 1'b0, 1'b0, 0, 0, 0, 1, (i < 255) ? i : 255);
        step("sat_fire", 16'h0042, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 255);
        step("sat_ack",  16'h0042, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 255);
        step("rearm",    16'h0100, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0);
        step("flip1",    16'h0100, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 1);

        // asynchronous reset while irq is high
        step("pre_rst", 16'h0042, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #2;
        rst = 1'b1;
        step("post0",   16'h0042, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step("post1",   16'h0042, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step("rearm2",  16'h0042, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0);
        step("fire2",   16'h0042, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        step("ack_end", 16'h0000, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
